// File: rtl/frame_updater.sv
// frame_updater: local LED frame buffer that streams changed bytes to the
// serial pixel writer over a valid/pos/value/busy handshake. It sends the
// data-mode command after reset, the display-control command whenever the
// brightness changes, and one transfer per dirty pixel (round-robin scan).
// Optional: define FRAME_UPDATER_AUTO_REFRESH_EN to force a full refresh
// every REFRESH_CYCLES clocks.
module frame_updater #(
  parameter int         NUM_PIXELS     = 16,
  parameter int         ADDR_W         = 4,
  parameter logic [7:0] DATA_CMD       = 8'h44,
  parameter logic [7:0] ADDR_CMD_BASE  = 8'hC0,
  parameter logic [7:0] DISP_CMD_BASE  = 8'h88,
  parameter int         REFRESH_CYCLES = 12_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              bright_wr,
  input  logic [2:0]        bright_in,
  output logic              out_valid,
  output logic [7:0]        out_pos,
  output logic [7:0]        out_value,
  input  logic              out_busy,
  output logic              idle
);

  typedef enum logic [2:0] {
    INIT_DATA,
    SCAN,
    ISSUE,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        fb [NUM_PIXELS];
  logic [NUM_PIXELS-1:0] dirty;
  logic [2:0]        brightness;
  logic              bright_pending;
  logic [ADDR_W-1:0] ptr;
  logic              pix_sent;
  logic              wr_ok;
  logic              refresh_tick;

  logic              load_en;
  logic              load_pix;
  logic [7:0]        load_pos;
  logic [7:0]        load_val;
  logic              clr_bright;
  logic              clr_dirty;
  logic              adv_ptr;
  logic              valid_nxt;

  if ((2 ** ADDR_W) < NUM_PIXELS) begin : g_bad_addr_w
    $error("ADDR_W too narrow for NUM_PIXELS");
  end
  if (REFRESH_CYCLES < 2) begin : g_bad_refresh
    $error("REFRESH_CYCLES must be at least 2");
  end

  // Out-of-range addresses are dropped entirely (no store, no dirty, no idle drop).
  assign wr_ok = wr_en && ({1'b0, wr_addr} < (ADDR_W + 1)'(NUM_PIXELS));

`ifdef FRAME_UPDATER_AUTO_REFRESH_EN
  localparam int CNT_W = $clog2(REFRESH_CYCLES);
  logic [CNT_W-1:0] refresh_cnt;

  assign refresh_tick = (refresh_cnt == CNT_W'(REFRESH_CYCLES - 1));

  // Free-running refresh period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            refresh_cnt <= '0;
    else if (refresh_tick) refresh_cnt <= '0;
    else                   refresh_cnt <= refresh_cnt + CNT_W'(1);
  end
`else
  assign refresh_tick = 1'b0;
`endif

  // Frame buffer, dirty bits and brightness; later sets override same-cycle clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_PIXELS; i++) fb[i] <= '0;
      dirty          <= '1;
      brightness     <= 3'd7;
      bright_pending <= 1'b1;
    end else begin
      if (clr_dirty) dirty[ptr] <= 1'b0;
      if (wr_ok) begin
        fb[wr_addr]    <= wr_data;
        dirty[wr_addr] <= 1'b1;
      end
      if (clr_bright) bright_pending <= 1'b0;
      if (bright_wr) begin
        brightness     <= bright_in;
        bright_pending <= 1'b1;
      end
      if (refresh_tick) begin
        dirty          <= '1;
        bright_pending <= 1'b1;
      end
    end
  end

  // Next-state and transfer-load decode.
  always_comb begin
    state_nxt  = state;
    load_en    = 1'b0;
    load_pix   = 1'b0;
    load_pos   = out_pos;
    load_val   = out_value;
    clr_bright = 1'b0;
    clr_dirty  = 1'b0;
    adv_ptr    = 1'b0;
    valid_nxt  = 1'b0;
    case (state)
      INIT_DATA: begin
        load_en   = 1'b1;
        load_pos  = 8'hFF;
        load_val  = DATA_CMD;
        state_nxt = ISSUE;
      end
      SCAN: begin
        if (bright_pending) begin
          load_en    = 1'b1;
          load_pos   = 8'hFF;
          load_val   = DISP_CMD_BASE | {5'b0, brightness};
          clr_bright = 1'b1;
          state_nxt  = ISSUE;
        end else if (dirty[ptr]) begin
          load_en   = 1'b1;
          load_pix  = 1'b1;
          load_pos  = ADDR_CMD_BASE | 8'(ptr);
          load_val  = fb[ptr];
          clr_dirty = 1'b1;
          state_nxt = ISSUE;
        end else begin
          adv_ptr = 1'b1;
        end
      end
      ISSUE: begin
        if (!out_busy) begin
          valid_nxt = 1'b1;
          state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (out_busy) state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (!out_busy) begin
          adv_ptr   = pix_sent;
          state_nxt = SCAN;
        end
      end
      default: state_nxt = INIT_DATA;
    endcase
  end

  // State register, held transfer outputs, scan pointer and idle flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT_DATA;
      out_valid <= 1'b0;
      out_pos   <= '0;
      out_value <= '0;
      ptr       <= '0;
      pix_sent  <= 1'b0;
      idle      <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= valid_nxt;
      if (load_en) begin
        out_pos   <= load_pos;
        out_value <= load_val;
        pix_sent  <= load_pix;
      end
      if (adv_ptr) begin
        if (ptr == ADDR_W'(NUM_PIXELS - 1)) ptr <= '0;
        else                                ptr <= ptr + ADDR_W'(1);
      end
      idle <= (state == SCAN) && !bright_pending && (dirty == '0) &&
              !wr_ok && !bright_wr && !refresh_tick;
    end
  end

endmodule

// File: doc/frame_updater.md
Name: frame_updater

Overview:
- Upstream stage of writepixels: holds a local 16-byte LED frame buffer and streams changed bytes to the serial pixel writer.
- Host logic writes pixels and brightness here at full clk rate. This block sequences TM1640-style transfers over the valid/pos/value/busy handshake:
  - init commands after reset;
  - brightness command on change;
  - one transfer per dirty pixel.
- pos=8'hFF marks a command-only transfer (downstream sends value byte only).

Parameters:
- NUM_PIXELS, 16, frame buffer depth in bytes; addresses 0..NUM_PIXELS-1.
- ADDR_W, 4, width of wr_addr; must satisfy 2**ADDR_W >= NUM_PIXELS.
- DATA_CMD, 8'h44, data-mode command sent once after reset (fixed-address mode).
- ADDR_CMD_BASE, 8'hC0, OR-ed with pixel address to form out_pos.
- DISP_CMD_BASE, 8'h88, OR-ed with brightness[2:0] to form the display-control command.
- REFRESH_CYCLES, 12_000_000, clk cycles between forced full refreshes (used only with the optional feature).

Ports:
- clk, input, 1, system clock (12 MHz nominal).
- rst_n, input, 1, asynchronous active-low reset.
- wr_en, input, 1, single-cycle pixel write strobe.
- wr_addr, input, ADDR_W, pixel address; writes with wr_addr >= NUM_PIXELS are ignored.
- wr_data, input, 8, pixel byte.
- bright_wr, input, 1, single-cycle brightness write strobe.
- bright_in, input, 3, brightness level 0..7.
- out_valid, output, 1, transfer request to writepixels.
- out_pos, output, 8, address byte (8'hFF = command).
- out_value, output, 8, data or command byte.
- out_busy, input, 1, writepixels busy.
- idle, output, 1, high when no dirty pixels, no pending command, and FSM in SCAN.

Behaviour:
- Reset (async, rst_n low):
  - out_valid=0, out_pos=0, out_value=0, idle=0.
  - Frame buffer cleared to 0; all dirty bits set; brightness=3'd7.
  - bright_pending=1, scan pointer=0, FSM=INIT_DATA.
- Storage and flags:
  - Frame buffer is a register array. wr_en writes the byte and sets dirty[wr_addr] on the same edge.
  - bright_wr latches bright_in and sets bright_pending.
- FSM states:
  - INIT_DATA: load out_pos=8'hFF, out_value=DATA_CMD → ISSUE.
  - SCAN: if bright_pending, load pos=8'hFF, value=DISP_CMD_BASE|brightness, clear bright_pending → ISSUE. Else if dirty[ptr], load pos=ADDR_CMD_BASE|ptr, value=fb[ptr], clear dirty[ptr] → ISSUE. Else advance ptr. Tests one address per cycle.
  - ISSUE: waits until out_busy=0, then asserts out_valid for exactly one cycle → WAIT_HI.
  - WAIT_HI: waits for out_busy=1 → WAIT_LO.
  - WAIT_LO: waits for out_busy=0. Advances ptr if a pixel was sent, then → SCAN.
- Scan pointer is round-robin and wraps NUM_PIXELS-1 → 0.
- Brightness always has priority over pixels.
- out_pos and out_value are held stable from load until the return to SCAN.
- Write during a transfer:
  - Data was snapshotted at load.
  - A wr_en to the address being sent sets its dirty bit again, so the new value is resent later.
- Simultaneous wr_en and dirty-clear on the same address and cycle: set wins (dirty stays 1, buffer takes new data).
- Simultaneous bright_wr and pending-clear: set wins; the new level is latched and sent again.
- Latency: a write to an idle block produces out_valid within NUM_PIXELS+2 cycles.
- idle rises the cycle after the FSM first finds nothing to do during a full pointer sweep. It falls on any wr_en or bright_wr.
- Reset mid-transfer: outputs drop immediately. The init sequence restarts after reset; downstream completes or aborts on its own.

Optional Feature:
- Macro: FRAME_UPDATER_AUTO_REFRESH_EN.
- Defined:
  - A free-running counter counts 0..REFRESH_CYCLES-1; reset value 0.
  - On wrap, sets all dirty bits and bright_pending, recovering the display from glitches.
  - Wrap coinciding with a clear: set wins.
- Undefined: no counter; transfers occur only after reset or on writes.

Test Plan:
- Reset release, out_busy model echoing 1 for 40 cycles after each valid:
  - Transfers in order: (FF,44), (FF,8F), then (C0,00)…(CF,00).
  - idle=1 afterwards; exactly 18 out_valid pulses.
- After idle, wr_en addr=5 data=A3:
  - Exactly one transfer (C5,A3); idle returns to 1.
- bright_wr level=2 while a pixel transfer is in WAIT_LO:
  - Next transfer is (FF,8A) before any queued pixel.
- wr_en addr=7 data=11 loaded, then addr=7 data=22 during WAIT_HI:
  - Transfers (C7,11) then (C7,22).
- wr_addr=15 with NUM_PIXELS=12: no transfer, idle stays 1.
- With FRAME_UPDATER_AUTO_REFRESH_EN, REFRESH_CYCLES=2000:
  - After idle, 17 transfers start at counter wrap (brightness first).
- rst_n pulsed low during WAIT_LO:
  - out_valid=0 immediately; the full 18-transfer init sequence repeats.
